// File: rtl/rv_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv_muldiv_pkg
// Brief  : Shared pipeline types for the M-extension multiply/divide unit.
// Rev    : 1.0 initial release
// ============================================================================
package rv_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef struct packed {
        logic is_alu;
        logic is_muldiv;
        logic is_load;
        logic is_store;
        logic is_branch;
    } control_t;

    localparam logic [6:0] MD_FUNCT7 = 7'b0000001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic md_signed_a(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_signed_b(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_muldiv_unit_div_step.sv
`default_nettype none
// ============================================================================
// Module : rv_div_restoring_step
// Brief  : One combinational restoring-division step (one quotient bit).
// Rev    : 1.0 initial release
// ============================================================================
module rv_div_restoring_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    // Dividend bits stream out of the top of quo while quotient bits enter below.
    assign w_shifted = {rem_i[XLEN-1:0], quo_i[XLEN-1]};
    assign w_diff    = w_shifted - {1'b0, divisor_i};

    always_comb begin
        if (!w_diff[XLEN]) begin
            rem_o = w_diff;
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = w_shifted;
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : rv_muldiv_unit
// Brief  : RV32M/RV64M multiply/divide unit with tagged valid/ready response.
// Rev    : 1.0 initial release
// ============================================================================
module rv_muldiv_unit
    import rv_muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 5,
    parameter int MUL_FAST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             kill,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    md_op_e            op_q;
    logic [TAG_W-1:0]  tag_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN:0]     rem_q;
    logic [XLEN-1:0]   res_q;

    md_op_e            w_op;
    logic              w_accept;
    logic              w_a_neg, w_b_neg, w_is_div, w_is_rem, w_neg;
    logic [XLEN-1:0]   w_abs_a, w_abs_b;
    logic              w_b_zero, w_ovf, w_fast;
    logic [XLEN-1:0]   w_fast_res, w_mul_fast_res, w_fix_res;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_acc_mul_nxt, w_prod_s;
    logic [XLEN:0]     w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt, w_quo_s, w_rem_s;

    assign w_op     = md_op_e'(req_op);
    assign w_accept = req_valid && req_ready;
    assign w_a_neg  = md_signed_a(w_op) && req_a[XLEN-1];
    assign w_b_neg  = md_signed_b(w_op) && req_b[XLEN-1];
    assign w_abs_a  = w_a_neg ? -req_a : req_a;
    assign w_abs_b  = w_b_neg ? -req_b : req_b;
    assign w_is_div = req_op[2];
    assign w_is_rem = req_op[2] && req_op[1];
    // Remainder follows the dividend sign; products and quotients follow a^b.
    assign w_neg    = w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_b_zero = (req_b == '0);
    assign w_ovf    = (w_op == MD_DIV || w_op == MD_REM) &&
                      (req_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_b == '1);

    generate
        if (MUL_FAST != 0) begin : g_mul_fast
            logic [2*XLEN-1:0] w_prod, w_prod_fs;
            assign w_prod         = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};
            assign w_prod_fs      = w_neg ? -w_prod : w_prod;
            assign w_mul_fast_res = (w_op == MD_MUL) ? w_prod_fs[XLEN-1:0]
                                                     : w_prod_fs[2*XLEN-1:XLEN];
        end else begin : g_mul_iter
            assign w_mul_fast_res = '0;
        end
    endgenerate

    assign w_fast = w_is_div ? (w_b_zero || w_ovf) : (MUL_FAST != 0);

    always_comb begin
        w_fast_res = w_mul_fast_res;
        if (w_is_div) begin
            if (w_b_zero)
                w_fast_res = w_is_rem ? req_a : '1;
            else
                w_fast_res = w_is_rem ? '0 : req_a;
        end
    end

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    assign w_mul_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                           (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign w_acc_mul_nxt = {w_mul_sum, acc_q[XLEN-1:1]};

    rv_div_restoring_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (acc_q[XLEN-1:0]),
        .divisor_i (opnd_q),
        .rem_o     (w_rem_nxt),
        .quo_o     (w_quo_nxt)
    );

    assign w_prod_s = neg_q ? -acc_q : acc_q;
    assign w_quo_s  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign w_rem_s  = neg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    always_comb begin
        if (op_q[2])
            w_fix_res = op_q[1] ? w_rem_s : w_quo_s;
        else if (op_q == MD_MUL)
            w_fix_res = w_prod_s[XLEN-1:0];
        else
            w_fix_res = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = w_fast ? ST_DONE : ST_CALC;
            ST_CALC:  if (cnt_q == '0) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (kill)
            state_d = ST_IDLE;
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE) && !kill;
        resp_valid = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            op_q   <= MD_MUL;
            tag_q  <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
            rem_q  <= '0;
            res_q  <= '0;
        end else if (w_accept) begin
            cnt_q  <= CNT_W'(XLEN-1);
            op_q   <= w_op;
            tag_q  <= req_tag;
            neg_q  <= w_neg;
            opnd_q <= w_is_div ? w_abs_b : w_abs_a;
            acc_q  <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
            rem_q  <= '0;
            if (w_fast)
                res_q <= w_fast_res;
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q[2]) begin
                rem_q               <= w_rem_nxt;
                acc_q[XLEN-1:0]     <= w_quo_nxt;
            end else begin
                acc_q <= w_acc_mul_nxt;
            end
        end else if (state_q == ST_FIXUP) begin
            res_q <= w_fix_res;
        end
    end

    assign resp_data = res_q;
    assign resp_tag  = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_rv_muldiv_unit
// Brief  : Directed bench for rv_muldiv_unit, iterative and fast-multiply builds.
// Rev    : 1.0 initial release
// ============================================================================
module tb_rv_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        kill = 1'b0;
    logic        resp_ready0 = 1'b1, resp_ready1 = 1'b1;

    logic        req_ready0, resp_valid0, busy0;
    logic [31:0] resp_data0;
    logic [4:0]  resp_tag0;
    logic        req_ready1, resp_valid1, busy1;
    logic [31:0] resp_data1;
    logic [4:0]  resp_tag1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_muldiv_unit #(.XLEN(32), .TAG_W(5), .MUL_FAST(0)) u_dut_iter (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .kill(kill), .resp_valid(resp_valid0), .resp_ready(resp_ready0),
        .resp_data(resp_data0), .resp_tag(resp_tag0), .busy(busy0)
    );

    rv_muldiv_unit #(.XLEN(32), .TAG_W(5), .MUL_FAST(1)) u_dut_fast (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .kill(kill), .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_data(resp_data1), .resp_tag(resp_tag1), .busy(busy1)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat0;
        int          lat1;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int lat0, input int lat1);
        int n = 1, got0 = 0, got1 = 0;
        logic [31:0] d0 = '0, d1 = '0;
        logic [4:0]  t0 = '0, t1 = '0;
        issue(op, a, b, tag);
        while (n <= 40) begin
            if (got0 == 0 && resp_valid0) begin got0 = n; d0 = resp_data0; t0 = resp_tag0; end
            if (got1 == 0 && resp_valid1) begin got1 = n; d1 = resp_data1; t1 = resp_tag1; end
            if (got0 != 0 && got1 != 0) break;
            step();
            n++;
        end
        step();
        chk({name, "_iter_data"}, 64'(d0), 64'(exp));
        chk({name, "_iter_lat"},  64'(got0), 64'(lat0));
        chk({name, "_iter_tag"},  64'(t0), 64'(tag));
        chk({name, "_fast_data"}, 64'(d1), 64'(exp));
        chk({name, "_fast_lat"},  64'(got1), 64'(lat1));
        chk({name, "_fast_tag"},  64'(t1), 64'(tag));
    endtask

    initial begin
        logic rose;
        vecs[0]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1};
        vecs[1]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1};
        vecs[2]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1, 1};
        vecs[3]  = '{3'd7, 32'd100,       32'd0,         32'd100,       1, 1};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 34};
        vecs[6]  = '{3'd5, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 34, 34};
        vecs[7]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1};
        vecs[8]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, 1};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1};
        vecs[10] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 1};
        vecs[11] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 34};
        vecs[12] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         34, 34};
        vecs[13] = '{3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF, 1, 1};
        vecs[14] = '{3'd6, 32'h8000_0000, 32'd0,         32'h8000_0000, 1, 1};
        vecs[15] = '{3'd0, 32'h1234_5678, 32'h10,        32'h2345_6780, 34, 1};
        vecs[16] = '{3'd3, 32'h1234_5678, 32'h10,        32'h0000_0001, 34, 1};
        vecs[17] = '{3'd7, 32'd1000,      32'd7,         32'd6,         34, 34};

        step();
        step();
        chk("rst_resp_valid", 64'(resp_valid0), 64'd0);
        chk("rst_busy",       64'(busy0), 64'd0);
        chk("rst_resp_data",  64'(resp_data0), 64'd0);
        chk("rst_resp_tag",   64'(resp_tag0), 64'd0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", 64'(req_ready0), 64'd1);

        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   5'(i + 1), vecs[i].exp, vecs[i].lat0, vecs[i].lat1);

        // Backpressure in DONE, then kill drops the held result.
        resp_ready0 = 1'b0;
        resp_ready1 = 1'b0;
        issue(3'd5, 32'd1000, 32'd7, 5'h15);
        for (int n = 0; n < 40 && !resp_valid0; n++) step();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 64'(resp_valid0), 64'd1);
            chk("hold_data",  64'(resp_data0), 64'd142);
            chk("hold_tag",   64'(resp_tag0), 64'h15);
            chk("hold_req_ready", 64'(req_ready0), 64'd0);
            step();
        end
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("kill_done_valid_iter", 64'(resp_valid0), 64'd0);
        chk("kill_done_valid_fast", 64'(resp_valid1), 64'd0);
        resp_ready0 = 1'b1;
        resp_ready1 = 1'b1;

        // Kill mid-CALC.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'h3);
        for (int k = 0; k < 9; k++) step();
        kill = 1'b1;
        step();
        chk("kill_calc_busy",  64'(busy0), 64'd0);
        chk("kill_calc_valid", 64'(resp_valid0), 64'd0);
        kill = 1'b0;
        #1;
        chk("kill_calc_ready", 64'(req_ready0), 64'd1);
        rose = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rose = rose | resp_valid0 | resp_valid1;
            step();
        end
        chk("kill_calc_never_valid", 64'(rose), 64'd0);

        // Kill together with a request: nothing is accepted.
        kill = 1'b1;
        req_valid = 1'b1;
        req_op = 3'd0;
        step();
        kill = 1'b0;
        req_valid = 1'b0;
        chk("kill_req_busy_iter", 64'(busy0), 64'd0);
        chk("kill_req_busy_fast", 64'(busy1), 64'd0);

        // Asynchronous reset mid-CALC.
        issue(3'd5, 32'd77, 32'd5, 5'h9);
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        #1;
        chk("arst_busy",  64'(busy0), 64'd0);
        chk("arst_valid", 64'(resp_valid0), 64'd0);
        chk("arst_data",  64'(resp_data0), 64'd0);
        chk("arst_tag",   64'(resp_tag0), 64'd0);
        step();
        rst = 1'b0;
        step();
        run_op("after_rst", 3'd5, 32'd9, 32'd3, 5'h4, 32'd3, 34, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
